// File: rtl/ysyx_24110006_mem_responder.sv
// ----------------------------------------------------------------------------
// ysyx_24110006_mem_responder
//
// Clocked, handshaked data-memory slave for the LSU. It accepts one request at
// a time, holds a word-addressed storage array, and returns read data or a
// write acknowledgement a programmable number of cycles after the accept.
//
// Ports:
//   i_clock, i_reset      clock; synchronous active-high reset
//   i_req_valid / o_req_ready   request handshake (ready only while IDLE)
//   i_req_wen             1 = write, 0 = read
//   i_req_addr            byte address, bits [1:0] ignored
//   i_req_wdata/i_req_wmask     lane-aligned write data and byte enables
//   o_rsp_valid / i_rsp_ready   response handshake
//   o_rsp_rdata           read word (0 for writes and errors)
//   o_rsp_err             address outside [ADDR_BASE, ADDR_BASE+4*DEPTH)
//
// Optional build macro YSYX_24110006_MEM_RAND_DELAY_EN adds an 8-bit LFSR
// (taps 8,6,5,4, seed 8'hA5) that stretches each response by 0-3 cycles.
// ----------------------------------------------------------------------------
module ysyx_24110006_mem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wmask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // Wide enough for LATENCY-1 plus up to 3 extra cycles of random delay.
  localparam int unsigned CNT_W = $clog2(LATENCY + 4);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem [DEPTH];
  logic              mem_we;
  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  delay_extra;

  // Unsigned 32-bit subtraction: addresses below ADDR_BASE wrap to huge
  // offsets, so a single compare covers both ends of the window.
  assign offset   = addr_q - ADDR_BASE;
  assign in_range = (offset < SPAN);
  assign idx      = offset[IDX_W+1:2];

`ifdef YSYX_24110006_MEM_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] lfsr_next;

  // Fibonacci form, taps 8,6,5,4; the value after advancing is the one used.
  assign lfsr_next   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign delay_extra = CNT_W'(lfsr_next[1:0]);
`else
  assign delay_extra = '0;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
`ifdef YSYX_24110006_MEM_RAND_DELAY_EN
    lfsr_d      = lfsr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          wen_d   = i_req_wen;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          wmask_d = i_req_wmask;
          cnt_d   = CNT_LOAD + delay_extra;
          state_d = S_BUSY;
`ifdef YSYX_24110006_MEM_RAND_DELAY_EN
          lfsr_d  = lfsr_next;
`endif
        end
      end

      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (!in_range) begin
            rsp_err_d = 1'b1;
          end else if (wen_q) begin
            mem_we = 1'b1;
          end else begin
            rsp_rdata_d = mem[idx];
          end
        end
      end

      S_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge value regardless of block ordering.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef YSYX_24110006_MEM_RAND_DELAY_EN
      lfsr_q      <= 8'hA5;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef YSYX_24110006_MEM_RAND_DELAY_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  // Request holding registers are only read while BUSY, after an accept has
  // loaded them, so they carry no reset.
  always_ff @(posedge i_clock) begin
    wen_q   <= wen_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wmask_q <= wmask_d;
  end

  // NOTE: the storage array has no reset (contents are undefined after
  // power-up); the write is gated by i_reset so a reset landing on the
  // commit edge abandons the access.
  always_ff @(posedge i_clock) begin
    if (mem_we && !i_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) begin
          mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_24110006_mem_responder.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_24110006_mem_responder. Two instances share stimulus:
// one with LATENCY=1 and one with LATENCY=4; 'sel' picks which one receives
// the request and whose outputs are compared. A transaction-level model
// (sparse word memory, address window test, reference LFSR) sets the
// expected outputs, and a negedge process compares them every cycle.
// ----------------------------------------------------------------------------
module tb_ysyx_24110006_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 1024;

`ifdef YSYX_24110006_MEM_RAND_DELAY_EN
  localparam int FIRST_LAT = 3;  // seed A5 -> 4A, low bits 2'b10
`else
  localparam int FIRST_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_ready;

  logic        ready1, valid1, err1;
  logic [31:0] rdata1;
  logic        ready4, valid4, err4;
  logic [31:0] rdata4;

  logic        act_ready, act_valid, act_err;
  logic [31:0] act_rdata;

  logic        exp_ready, exp_valid, exp_err;
  logic [31:0] exp_rdata;
  logic        chk_en;

  int n_checks = 0;
  int n_fail   = 0;

  bit [31:0]   mdl_mem [bit [32:0]];
  logic [7:0]  mdl_lfsr [2];

  always #5 clk = ~clk;

  ysyx_24110006_mem_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid & ~sel),
    .o_req_ready (ready1),
    .i_req_wen   (req_wen),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_wmask (req_wmask),
    .o_rsp_valid (valid1),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rdata1),
    .o_rsp_err   (err1)
  );

  ysyx_24110006_mem_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .LATENCY(4)) dut4 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid & sel),
    .o_req_ready (ready4),
    .i_req_wen   (req_wen),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_wmask (req_wmask),
    .o_rsp_valid (valid4),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rdata4),
    .o_rsp_err   (err4)
  );

  assign act_ready = sel ? ready4 : ready1;
  assign act_valid = sel ? valid4 : valid1;
  assign act_rdata = sel ? rdata4 : rdata1;
  assign act_err   = sel ? err4   : err1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the selected instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", {31'b0, act_ready}, {31'b0, exp_ready});
      check("rsp_valid", {31'b0, act_valid}, {31'b0, exp_valid});
      check("rsp_rdata", act_rdata, exp_rdata);
      check("rsp_err",   {31'b0, act_err},   {31'b0, exp_err});
    end
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    longint unsigned x = longint'(a);
    return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * longint'(DEPTH));
  endfunction

  task automatic set_idle();
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_rdata = '0;
    exp_err   = 1'b0;
  endtask

  // Latency this transaction must have, advancing the reference LFSR.
  task automatic model_latency(input bit s, output int l);
    l = s ? 4 : 1;
`ifdef YSYX_24110006_MEM_RAND_DELAY_EN
    mdl_lfsr[s] = lfsr_step(mdl_lfsr[s]);
    l += int'(mdl_lfsr[s][1:0]);
`endif
  endtask

  // Drive one request at posedge+1, accept on the next edge, then scramble
  // the request inputs so any late sampling shows up.
  task automatic drive_req(input bit s, input bit wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input bit early_ready);
    sel       = s;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    req_valid = 1'b1;
    rsp_ready = early_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wen   = ~wen;
    req_addr  = addr ^ 32'h0000_0FF0;
    req_wdata = ~wdata;
    req_wmask = ~wmask;
    exp_ready = 1'b0;
    exp_valid = 1'b0;
    exp_rdata = '0;
    exp_err   = 1'b0;
  endtask

  task automatic txn(input bit s, input bit wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int l;
    bit [32:0] key;
    bit [31:0] word;
    model_latency(s, l);
    drive_req(s, wen, addr, wdata, wmask, hold == 0);
    lat = -1;
    for (int k = 1; k <= l; k++) begin
      @(posedge clk); #1;
      if (act_valid === 1'b1 && lat < 0) lat = k;
    end
    exp_valid = 1'b1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    key = {s, addr[31:2], 2'b00};
    if (!in_window(addr)) begin
      exp_err = 1'b1;
    end else if (wen) begin
      word = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (wmask[b]) word[8*b +: 8] = wdata[8*b +: 8];
      mdl_mem[key] = word;
    end else begin
      exp_rdata = mdl_mem.exists(key) ? mdl_mem[key] : 32'hx;
    end
    rd = act_rdata;
    er = act_err;
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_idle();
  endtask

  // Accept a request, then reset on the edge that would have committed it.
  task automatic txn_abort(input bit s, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask);
    int l;
    model_latency(s, l);
    drive_req(s, 1'b1, addr, wdata, wmask, 1'b0);
    repeat (l - 1) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_lfsr[0] = 8'hA5;
    mdl_lfsr[1] = 8'hA5;
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] rd_addrs [8];

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;
    chk_en = 1'b0;
    mdl_lfsr[0] = 8'hA5;
    mdl_lfsr[1] = 8'hA5;
    set_idle();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: full-word write, then read back.
    txn(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    check("t1_wr_rdata", rd, 32'h0);
    check("t1_wr_err", {31'b0, er}, 32'h0);
    check("t1_latency", 32'(lat), 32'(FIRST_LAT));
    txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    check("t1_rd", rd, 32'hDEAD_BEEF);

    // 2: single-lane write, then zero-mask write.
    txn(0, 1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, 0, rd, er, lat);
    txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    check("t2_lane_rd", rd, 32'hDEAD_ABEF);
    txn(0, 1, 32'h8000_0013, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat);
    txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    check("t2_mask0_rd", rd, 32'hDEAD_ABEF);

    // 3: window edges; stray accesses must not alias onto stored words.
    txn(0, 1, 32'h8000_0000, 32'h0123_4567, 4'hF, 0, rd, er, lat);
    txn(0, 1, 32'h8000_0FFC, 32'h89AB_CDEF, 4'hF, 0, rd, er, lat);
    txn(0, 1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
    check("t3_wr_hi_err", {31'b0, er}, 32'h1);
    txn(0, 1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
    check("t3_wr_lo_err", {31'b0, er}, 32'h1);
    txn(0, 0, 32'h8000_1000, 32'h0, 4'h0, 0, rd, er, lat);
    check("t3_rd_hi_err", {31'b0, er}, 32'h1);
    check("t3_rd_hi_data", rd, 32'h0);
    txn(0, 0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd, er, lat);
    check("t3_rd_lo_err", {31'b0, er}, 32'h1);
    txn(0, 0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, rd, er, lat);
    check("t3_rd_top_err", {31'b0, er}, 32'h1);
    txn(0, 0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, lat);
    check("t3_word0", rd, 32'h0123_4567);
    txn(0, 0, 32'h8000_0FFC, 32'h0, 4'h0, 0, rd, er, lat);
    check("t3_last_word", rd, 32'h89AB_CDEF);
    check("t3_last_err", {31'b0, er}, 32'h0);

    // 4: response held for 5 cycles with rsp_ready low.
    txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 5, rd, er, lat);
    check("t4_hold_rd", rd, 32'hDEAD_ABEF);

    // 5: reset on the commit edge of a LATENCY=4 write.
    txn(1, 1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, rd, er, lat);
    txn_abort(1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF);
    txn(1, 0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, lat);
    check("t5_after_abort", rd, 32'h1122_3344);
    txn(1, 0, 32'h8000_0020, 32'h0, 4'h0, 2, rd, er, lat);

    // 6: back-to-back reads; per-cycle checks track the LFSR-driven latency.
    rd_addrs = '{32'h8000_0010, 32'h8000_0000, 32'h8000_0FFC, 32'h8000_1000,
                 32'h8000_0010, 32'h8000_0FFC, 32'h8000_0000, 32'h8000_0010};
    for (int i = 0; i < 8; i++) begin
      txn(0, 0, rd_addrs[i], 32'h0, 4'h0, 0, rd, er, lat);
    end
    check("t6_last_rd", rd, 32'hDEAD_ABEF);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
